mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Accepts one start pulse per operation and sequences a fixed-latency multi-cycle operation.
- Owns the HI/LO registers and drives the busy/start pair the hazard unit uses to stall D-stage mult/div/mfhi/mflo/mthi/mtlo.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_calc.sv | 44 ++++
 rtl/mdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
// MADD family codes are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MADD  = 4'd7;
   localparam logic [3:0] MD_MADDU = 4'd8;
   localparam logic [3:0] MD_MSUB  = 4'd9;
   localparam logic [3:0] MD_MSUBU = 4'd10;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   typedef enum logic [1:0] {
      CM_KEEP,
      CM_LOAD,
      CM_ADD,
      CM_SUB
   } commit_e;

   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_DIV) ||
             (op == MD_MADD) || (op == MD_MSUB);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit product, quotient/remainder and div-by-zero flag.
// Signed division works on magnitudes so INT_MIN / -1 wraps cleanly.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [63:0] prod,
   output logic [31:0] quot,
   output logic [31:0] rem,
   output logic        div_zero
);

   logic        sgn;
   logic        a_neg;
   logic        b_neg;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] uq;
   logic [31:0] ur;

   always_comb begin
      sgn      = is_signed_op(md_op);
      a_neg    = sgn & src_a[31];
      b_neg    = sgn & src_b[31];
      a_ext    = {{32{a_neg}}, src_a};
      b_ext    = {{32{b_neg}}, src_b};
      prod     = a_ext * b_ext;
      a_mag    = a_neg ? -src_a : src_a;
      b_mag    = b_neg ? -src_b : src_b;
      div_zero = (src_b == 32'd0);
      // keep the divider free of X when the result is discarded anyway
      b_safe   = div_zero ? 32'd1 : b_mag;
      uq       = a_mag / b_safe;
      ur       = a_mag % b_safe;
      quot     = (a_neg ^ b_neg) ? -uq : uq;
      rem      = a_neg ? -ur : ur;
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO and the busy flag.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        ignored
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

   state_e      state_q, state_d;
   commit_e     cmode_q, cmode_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        ign_q, ign_d;

   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div_zero;

   logic        is_mul;
   logic        is_div;
   logic        is_acc;
   logic        acc_sub;
   logic        is_mthi;
   logic        is_mtlo;
   logic        known;

   mdu_calc u_calc (
      .md_op    (md_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .prod     (prod),
      .quot     (quot),
      .rem      (rem),
      .div_zero (div_zero)
   );

   always_comb begin
      is_mul  = (md_op == MD_MULT) || (md_op == MD_MULTU);
      is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
      is_mthi = (md_op == MD_MTHI);
      is_mtlo = (md_op == MD_MTLO);
      is_acc  = 1'b0;
      acc_sub = 1'b0;
`ifdef MDU_MADD_EN
      is_acc  = (md_op == MD_MADD) || (md_op == MD_MADDU) ||
                (md_op == MD_MSUB) || (md_op == MD_MSUBU);
      acc_sub = (md_op == MD_MSUB) || (md_op == MD_MSUBU);
`endif
      known   = is_mul | is_div | is_acc | is_mthi | is_mtlo;
   end

   always_comb begin
      state_d = state_q;
      cmode_d = cmode_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ign_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               unique case (1'b1)
                  is_mul | is_acc: begin
                     pend_d  = prod;
                     cnt_d   = MULT_CNT;
                     state_d = S_RUN;
                     if (!is_acc)
                        cmode_d = CM_LOAD;
                     else if (acc_sub)
                        cmode_d = CM_SUB;
                     else
                        cmode_d = CM_ADD;
                  end
                  is_div: begin
                     pend_d  = {rem, quot};
                     cnt_d   = DIV_CNT;
                     state_d = S_RUN;
                     cmode_d = div_zero ? CM_KEEP : CM_LOAD;
                  end
                  is_mthi: hi_d = src_a;
                  is_mtlo: lo_d = src_a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            ign_d = start & known;
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               // accumulate uses HI/LO as they stand at commit time
               unique case (cmode_q)
                  CM_LOAD: {hi_d, lo_d} = pend_q;
                  CM_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                  CM_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cmode_q <= CM_KEEP;
         cnt_q   <= 4'd0;
         pend_q  <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         ign_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmode_q <= cmode_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         ign_q   <= ign_d;
      end
   end

   assign busy    = busy_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign ignored = ign_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with an arithmetic reference model.
// Honors MDU_MADD_EN the same way the design does.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        ignored;

   int checks = 0;
   int errors = 0;

   mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .src_a   (src_a),
      .src_b   (src_b),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .ignored (ignored)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: remaining busy cycles plus the result to apply
   int          m_left;
   logic [63:0] m_res;
   int          m_kind;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_ign;

   function automatic bit op_known(input logic [3:0] o);
      bit k;
      k = (o >= MD_MULT && o <= MD_MTLO);
`ifdef MDU_MADD_EN
      k = k || (o >= MD_MADD && o <= MD_MSUBU);
`endif
      return k;
   endfunction

   function automatic logic [63:0] mul_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit sg);
      longint p;
      if (sg)
         p = longint'($signed(a)) * longint'($signed(b));
      else
         p = longint'({32'd0, a}) * longint'({32'd0, b});
      return p;
   endfunction

   function automatic logic [63:0] div_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit sg);
      longint q;
      longint r;
      if (sg) begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
      end else begin
         q = longint'({32'd0, a}) / longint'({32'd0, b});
         r = longint'({32'd0, a}) % longint'({32'd0, b});
      end
      return {r[31:0], q[31:0]};
   endfunction

   // kinds: 0 keep, 1 load, 2 add, 3 sub
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left <= 0;
         m_res  <= 64'd0;
         m_kind <= 0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_ign  <= 1'b0;
      end else begin
         m_ign <= (m_left != 0) && start && op_known(md_op);
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               case (m_kind)
                  1: {m_hi, m_lo} <= m_res;
                  2: {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
                  3: {m_hi, m_lo} <= {m_hi, m_lo} - m_res;
                  default: ;
               endcase
            end
         end else if (start) begin
            case (md_op)
               MD_MULT, MD_MULTU: begin
                  m_res  <= mul_ref(src_a, src_b, md_op == MD_MULT);
                  m_kind <= 1;
                  m_left <= ML;
               end
               MD_DIV, MD_DIVU: begin
                  m_left <= DL;
                  if (src_b == 32'd0) begin
                     m_kind <= 0;
                  end else begin
                     m_kind <= 1;
                     m_res  <= div_ref(src_a, src_b, md_op == MD_DIV);
                  end
               end
               MD_MTHI: m_hi <= src_a;
               MD_MTLO: m_lo <= src_a;
`ifdef MDU_MADD_EN
               MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                  m_res  <= mul_ref(src_a, src_b,
                                    md_op == MD_MADD || md_op == MD_MSUB);
                  m_kind <= (md_op == MD_MSUB || md_op == MD_MSUBU) ? 3 : 2;
                  m_left <= ML;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_left != 0});
      chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
      chk("cyc_ignored", {63'd0, ignored}, {63'd0, m_ign});
   end

   task automatic op_now(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      #2;
      start = 1'b1;
      md_op = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = MD_NONE;
   endtask

   task automatic op(input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b);
      @(negedge clk);
      op_now(o, a, b);
   endtask

   // counts busy negedges; returns at the negedge where busy is low
   task automatic busy_len(output int n);
      bit done;
      n = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy)
            n++;
         else
            done = 1;
      end
   endtask

   int n;

   initial begin
      reset = 1'b0;
      start = 1'b0;
      md_op = MD_NONE;
      src_a = 32'd0;
      src_b = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      #2 reset = 1'b1;

      op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      busy_len(n);
      chk("mult_len", 64'(n), 64'd5);
      chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

      op(MD_DIVU, 32'd100, 32'd7);
      busy_len(n);
      chk("divu_len", 64'(n), 64'd10);
      chk("divu_lo", {32'd0, lo}, 64'd14);
      chk("divu_hi", {32'd0, hi}, 64'd2);

      op_now(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      busy_len(n);
      chk("div_b2b_len", 64'(n), 64'd10);
      chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

      op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      busy_len(n);
      chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);
      chk("ovf_hi", {32'd0, hi}, 64'd0);

      op(MD_MTHI, 32'h11, 32'd0);
      op(MD_MTLO, 32'h22, 32'd0);
      @(negedge clk);
      chk("mt_busy", {63'd0, busy}, 64'd0);
      op(MD_DIV, 32'd5, 32'd0);
      busy_len(n);
      chk("dz_len", 64'(n), 64'd10);
      chk("dz_hi", {32'd0, hi}, 64'h11);
      chk("dz_lo", {32'd0, lo}, 64'h22);

      op(MD_NONE, 32'hDEAD, 32'd1);
      @(negedge clk);
      chk("none_busy", {63'd0, busy}, 64'd0);
      chk("none_lo", {32'd0, lo}, 64'h22);

      op(MD_MULTU, 32'h0001_0000, 32'h0001_0001);
      @(posedge clk);
      #1;
      start = 1'b1;
      md_op = MD_MTLO;
      src_a = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = MD_NONE;
      @(negedge clk);
      chk("ign_pulse", {63'd0, ignored}, 64'd1);
      busy_len(n);
      chk("ign_hi", {32'd0, hi}, 64'd1);
      chk("ign_lo", {32'd0, lo}, 64'h0001_0000);

      op(MD_DIV, 32'd50, 32'd3);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_hi", {32'd0, hi}, 64'd0);
      chk("arst_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      op(MD_MULT, 32'd7, 32'd6);
      busy_len(n);
      chk("post_len", 64'(n), 64'd5);
      chk("post_lo", {32'd0, lo}, 64'd42);

      op(MD_MTHI, 32'd0, 32'd0);
      op(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
      op(MD_MADDU, 32'd1, 32'd1);
      busy_len(n);
`ifdef MDU_MADD_EN
      chk("madd_len", 64'(n), 64'd5);
      chk("madd_hi", {32'd0, hi}, 64'd1);
      chk("madd_lo", {32'd0, lo}, 64'd0);
`else
      chk("madd_len", 64'(n), 64'd0);
      chk("madd_hi", {32'd0, hi}, 64'd0);
      chk("madd_lo", {32'd0, lo}, 64'hFFFF_FFFF);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
